add_sub_pipe: RTL

- Parametrised, two-stage pipelined integer adder/subtractor with a valid/ready stream interface.
- Selects add or subtract per transaction.
- Returns the result with carry/borrow, signed overflow, zero and true-sign flags.
- Feeds the FPU exponent/mantissa datapath.
- The carry chain is split across two registered stages so that wide operands close timing.

---
 rtl/add_sub_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/add_sub_pipe.sv
// Two-stage pipelined add/subtract with valid/ready handshake.
// The carry chain is split at LO_W so each stage closes timing on wide operands.
module add_sub_pipe #(
    parameter int W    = 32,
    parameter int LO_W = W / 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_op,
    input  logic         in_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_cb,
    output logic         out_ovf,
    output logic         out_zero,
    output logic         out_neg
);
    localparam int HI_W = W - LO_W;

    // Handshake
    logic adv1;
    logic adv2;
    logic accept;

    // Stage 1 state
    logic            v1_reg;
    logic [LO_W-1:0] lo_reg;
    logic            c_lo_reg;
    logic [HI_W-1:0] a_hi_reg;
    logic [HI_W-1:0] b_hi_reg;
    logic            op1_reg;
    logic            sgn1_reg;

    // Stage 2 state
    logic         v2_reg;
    logic [W-1:0] y_reg;
    logic         cb_reg;
    logic         ovf_reg;
    logic         zero_reg;
    logic         neg_reg;

    // Stage 1 combinational
    logic [W-1:0]  b_eff;
    logic [LO_W:0] lo_sum;

    // Stage 2 combinational
    logic [HI_W:0] hi_sum;
    logic [W-1:0]  y_next;
    logic          cout;
    logic          cmsb;
    logic          cb_next;
    logic          ovf_next;
    logic          zero_next;
    logic          neg_next;

    assign adv2     = !v2_reg || out_ready;
    assign adv1     = !v1_reg || adv2;
    assign in_ready = adv1;
    assign accept   = in_valid && adv1;

    // Subtraction is A + ~B + 1; the +1 enters as the low-slice carry-in.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_beff
            assign b_eff[gi] = in_b[gi] ^ in_op;
        end
    endgenerate

    assign lo_sum = {1'b0, in_a[LO_W-1:0]} + {1'b0, b_eff[LO_W-1:0]}
                  + {{LO_W{1'b0}}, in_op};

    assign hi_sum = {1'b0, a_hi_reg} + {1'b0, b_hi_reg}
                  + {{HI_W{1'b0}}, c_lo_reg};

    always_comb begin
        y_next    = {hi_sum[HI_W-1:0], lo_reg};
        cout      = hi_sum[HI_W];
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        cmsb      = a_hi_reg[HI_W-1] ^ b_hi_reg[HI_W-1] ^ hi_sum[HI_W-1];
        cb_next   = op1_reg ? !cout : cout;
        ovf_next  = sgn1_reg && (cmsb ^ cout);
        zero_next = (y_next == '0);
        neg_next  = sgn1_reg && (y_next[W-1] ^ ovf_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg   <= 1'b0;
            lo_reg   <= '0;
            c_lo_reg <= 1'b0;
            a_hi_reg <= '0;
            b_hi_reg <= '0;
            op1_reg  <= 1'b0;
            sgn1_reg <= 1'b0;
            v2_reg   <= 1'b0;
            y_reg    <= '0;
            cb_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
        end else begin
            if (adv1) begin
                v1_reg <= accept;
            end
            if (accept) begin
                lo_reg   <= lo_sum[LO_W-1:0];
                c_lo_reg <= lo_sum[LO_W];
                a_hi_reg <= in_a[W-1:LO_W];
                b_hi_reg <= b_eff[W-1:LO_W];
                op1_reg  <= in_op;
                sgn1_reg <= in_signed;
            end
            if (adv2) begin
                v2_reg <= v1_reg;
                // Output registers only change when a real result moves in.
                if (v1_reg) begin
                    y_reg    <= y_next;
                    cb_reg   <= cb_next;
                    ovf_reg  <= ovf_next;
                    zero_reg <= zero_next;
                    neg_reg  <= neg_next;
                end
            end
        end
    end

    assign out_valid = v2_reg;
    assign out_y     = y_reg;
    assign out_cb    = cb_reg;
    assign out_ovf   = ovf_reg;
    assign out_zero  = zero_reg;
    assign out_neg   = neg_reg;

endmodule
